// File: rtl/textmap_ctrl_if.sv
// Bus bundle for textmap_ctrl: CPU access port, engine command port and text map RAM port.
// The slave modport is the controller's view; master is the surrounding system.
interface textmap_ctrl_if #(
  parameter int TRAM_AW = 11,
  parameter int TRAM_DW = 32
);
  logic               cpu_req;
  logic               cpu_we;
  logic [TRAM_AW-1:0] cpu_addr;
  logic [TRAM_DW-1:0] cpu_wdata;
  logic               cpu_ack;
  logic [TRAM_DW-1:0] cpu_rdata;
  logic               cmd_valid;
  logic [1:0]         cmd_op;
  logic [7:0]         cmd_row;
  logic               cmd_ready;
  logic               busy;
  logic               done;
  logic [TRAM_AW-1:0] tram_addr;
  logic               tram_we;
  logic               tram_re;
  logic [TRAM_DW-1:0] tram_wdata;
  logic [TRAM_DW-1:0] tram_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cmd_valid, cmd_op, cmd_row, tram_rdata,
    input  cpu_ack, cpu_rdata, cmd_ready, busy, done, tram_addr, tram_we, tram_re, tram_wdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cmd_valid, cmd_op, cmd_row, tram_rdata,
    output cpu_ack, cpu_rdata, cmd_ready, busy, done, tram_addr, tram_we, tram_re, tram_wdata
  );
endinterface

// File: rtl/textmap_ctrl.sv
// Text map RAM controller: arbitrates one RAM port between CPU accesses and a clear/scroll engine.
// Define TEXTMAP_CPU_PRIORITY_EN to make the CPU win every contention (no fairness pointer).
module textmap_ctrl #(
  parameter int                 TRAM_AW    = 11,
  parameter int                 TRAM_DW    = 32,
  parameter int                 TEXT_W     = 84,
  parameter int                 TEXT_H     = 24,
  parameter logic [TRAM_DW-1:0] CLEAR_WORD = {TRAM_DW{1'b0}}
) (
  input  logic          clk_sys,
  input  logic          rst_sys_n,
  textmap_ctrl_if.slave bus
);

  localparam logic [TRAM_AW-1:0] LAST_ADDR = TRAM_AW'(TEXT_W * TEXT_H - 1);
  localparam logic [TRAM_AW-1:0] ROW_W     = TRAM_AW'(TEXT_W);
  localparam logic [TRAM_AW-1:0] ONE_A     = TRAM_AW'(1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_SRD  = 3'd2,
    ST_SWT  = 3'd3,
    ST_SWR  = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  state_t             state_r, state_s;
  logic [TRAM_AW-1:0] dst_r, dst_s, src_r, src_s, end_r, end_s;
  logic [TRAM_DW-1:0] hold_r, hold_s;
  logic [TRAM_AW-1:0] row_base_s;
  logic               cpu_ack_r, cpu_rd_r;
  logic [TRAM_DW-1:0] rdata_r;
  logic [TRAM_AW-1:0] addr_r;
  logic [TRAM_DW-1:0] wdata_r;
  logic               cpu_req_s, eng_req_s, eng_we_s, grant_cpu_s, grant_eng_s;
  logic [TRAM_AW-1:0] eng_addr_s;
  logic [TRAM_DW-1:0] eng_wdata_s;
`ifndef TEXTMAP_CPU_PRIORITY_EN
  logic               fair_cpu_r, fair_cpu_s;
`endif

  // Arbiter: CPU request is masked during its own ack cycle
  always_comb begin
    cpu_req_s = bus.cpu_req & ~cpu_ack_r;
    eng_req_s = (state_r == ST_CLR) | (state_r == ST_SRD) | (state_r == ST_SWR);
`ifdef TEXTMAP_CPU_PRIORITY_EN
    grant_cpu_s = cpu_req_s;
`else
    fair_cpu_s = fair_cpu_r;
    if (cpu_req_s && eng_req_s) begin
      grant_cpu_s = fair_cpu_r;
      fair_cpu_s  = ~fair_cpu_r;
    end else begin
      grant_cpu_s = cpu_req_s;
    end
`endif
    grant_eng_s = eng_req_s & ~grant_cpu_s;
  end

  // RAM port mux; address and write data hold their last value when nothing is granted
  always_comb begin
    eng_we_s    = (state_r != ST_SRD);
    eng_addr_s  = (state_r == ST_SRD) ? src_r : dst_r;
    eng_wdata_s = (state_r == ST_SWR) ? hold_r : CLEAR_WORD;
    bus.tram_we = grant_cpu_s ? bus.cpu_we  : (grant_eng_s & eng_we_s);
    bus.tram_re = grant_cpu_s ? ~bus.cpu_we : (grant_eng_s & ~eng_we_s);
    if (grant_cpu_s) begin
      bus.tram_addr = bus.cpu_addr;
    end else if (grant_eng_s) begin
      bus.tram_addr = eng_addr_s;
    end else begin
      bus.tram_addr = addr_r;
    end
    if (grant_cpu_s && bus.cpu_we) begin
      bus.tram_wdata = bus.cpu_wdata;
    end else if (grant_eng_s && eng_we_s) begin
      bus.tram_wdata = eng_wdata_s;
    end else begin
      bus.tram_wdata = wdata_r;
    end
    bus.cpu_ack   = cpu_ack_r;
    bus.cpu_rdata = cpu_rd_r ? bus.tram_rdata : rdata_r;
    bus.cmd_ready = (state_r == ST_IDLE);
    bus.busy      = (state_r != ST_IDLE);
    bus.done      = (state_r == ST_DONE);
  end

  // Engine next-state: dst walks the destination, src trails one row below while scrolling
  always_comb begin
    state_s    = state_r;
    dst_s      = dst_r;
    src_s      = src_r;
    end_s      = end_r;
    hold_s     = hold_r;
    row_base_s = TRAM_AW'(bus.cmd_row) * ROW_W;
    case (state_r)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd_op)
            2'd0: begin
              state_s = ST_CLR;
              dst_s   = {TRAM_AW{1'b0}};
              end_s   = LAST_ADDR;
            end
            2'd1: begin
              if (bus.cmd_row < 8'(TEXT_H)) begin
                state_s = ST_CLR;
                dst_s   = row_base_s;
                end_s   = row_base_s + ROW_W - ONE_A;
              end else begin
                state_s = ST_DONE;
              end
            end
            2'd2: begin
              state_s = ST_SRD;
              dst_s   = {TRAM_AW{1'b0}};
              src_s   = ROW_W;
            end
            default: state_s = ST_DONE;
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CLR: begin
        if (grant_eng_s) begin
          if (dst_r == end_r) begin
            state_s = ST_DONE;
          end else begin
            dst_s = dst_r + ONE_A;
          end
        end else begin
          state_s = ST_CLR;
        end
      end
      ST_SRD: begin
        if (grant_eng_s) begin
          state_s = ST_SWT;
        end else begin
          state_s = ST_SRD;
        end
      end
      ST_SWT: begin
        hold_s  = bus.tram_rdata;
        state_s = ST_SWR;
      end
      ST_SWR: begin
        if (grant_eng_s) begin
          dst_s = dst_r + ONE_A;
          src_s = src_r + ONE_A;
          if (src_r == LAST_ADDR) begin
            state_s = ST_CLR;
            end_s   = LAST_ADDR;
          end else begin
            state_s = ST_SRD;
          end
        end else begin
          state_s = ST_SWR;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Engine state and counters
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_r <= ST_IDLE;
      dst_r   <= {TRAM_AW{1'b0}};
      src_r   <= {TRAM_AW{1'b0}};
      end_r   <= {TRAM_AW{1'b0}};
      hold_r  <= {TRAM_DW{1'b0}};
    end else begin
      state_r <= state_s;
      dst_r   <= dst_s;
      src_r   <= src_s;
      end_r   <= end_s;
      hold_r  <= hold_s;
    end
  end

  // CPU ack/read-data tracking and RAM port hold registers
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      cpu_ack_r <= 1'b0;
      cpu_rd_r  <= 1'b0;
      rdata_r   <= {TRAM_DW{1'b0}};
      addr_r    <= {TRAM_AW{1'b0}};
      wdata_r   <= {TRAM_DW{1'b0}};
    end else begin
      cpu_ack_r <= grant_cpu_s;
      cpu_rd_r  <= grant_cpu_s & ~bus.cpu_we;
      rdata_r   <= cpu_rd_r ? bus.tram_rdata : rdata_r;
      addr_r    <= bus.tram_addr;
      wdata_r   <= bus.tram_wdata;
    end
  end

`ifndef TEXTMAP_CPU_PRIORITY_EN
  // Fairness pointer: set means the CPU wins the next contention
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      fair_cpu_r <= 1'b1;
    end else begin
      fair_cpu_r <= fair_cpu_s;
    end
  end
`endif

endmodule

// File: tb/tb_textmap_ctrl.sv
// Self-checking bench for textmap_ctrl: RAM model, queue-based reference model checked every cycle,
// directed scenarios with literal expectations and randomized CPU/command traffic.
module tb_textmap_ctrl;
  localparam int AW = 11;
  localparam int DW = 32;
  localparam int TW = 84;
  localparam int TH = 24;
  localparam int NW = TW * TH;
`ifdef TEXTMAP_CPU_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif
  localparam logic [1:0] K_W = 2'd0, K_R = 2'd1, K_WAIT = 2'd2;

  typedef struct {
    logic [1:0]    kind;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            use_hold;
  } step_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  textmap_ctrl_if #(.TRAM_AW(AW), .TRAM_DW(DW)) bus ();

  textmap_ctrl #(.TRAM_AW(AW), .TRAM_DW(DW), .TEXT_W(TW), .TEXT_H(TH), .CLEAR_WORD(32'h0)) dut (
    .clk_sys  (clk),
    .rst_sys_n(rst_n),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_fail = 0;

  logic [DW-1:0] ram [0:2047];
  logic [DW-1:0] shadow [0:2047];
  bit preload_go = 1'b0;
  bit preload_kind = 1'b0;
  bit cpu_stop = 1'b0;

  function automatic logic [DW-1:0] pre_val(input int i, input bit kind);
    if (kind && i < NW) return DW'(i / TW + 1);
    return {DW{1'b0}};
  endfunction

  // Synchronous single-port RAM with one-cycle read latency
  always @(posedge clk) begin
    if (preload_go) begin
      for (int i = 0; i < 2048; i++) ram[i] <= pre_val(i, preload_kind);
    end
    if (bus.tram_re) bus.tram_rdata <= ram[bus.tram_addr];
    if (bus.tram_we) ram[bus.tram_addr] <= bus.tram_wdata;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: engine work is a queue of RAM steps; arbitration per the fairness rule
  step_t q[$];
  int m_mode = 0;             // 0 idle, 1 working, 2 done pulse
  bit m_ack = 1'b0;
  bit m_ptr_cpu = 1'b1;
  logic [DW-1:0] m_rdata = '0, m_hold = '0, m_last_wdata = '0;
  logic [AW-1:0] m_last_addr = '0;

  function automatic step_t mk(input logic [1:0] k, input int a, input logic [DW-1:0] d, input bit h);
    step_t s;
    s.kind = k; s.addr = AW'(a); s.data = d; s.use_hold = h;
    return s;
  endfunction

  function automatic void build(input logic [1:0] op, input logic [7:0] row);
    q.delete();
    if (op == 2'd0) begin
      for (int a = 0; a < NW; a++) q.push_back(mk(K_W, a, 32'h0, 1'b0));
    end else if (op == 2'd1) begin
      if (int'(row) < TH) for (int c = 0; c < TW; c++) q.push_back(mk(K_W, int'(row) * TW + c, 32'h0, 1'b0));
    end else if (op == 2'd2) begin
      for (int i = 0; i < NW - TW; i++) begin
        q.push_back(mk(K_R, i + TW, 32'h0, 1'b0));
        q.push_back(mk(K_WAIT, 0, 32'h0, 1'b0));
        q.push_back(mk(K_W, i, 32'h0, 1'b1));
      end
      for (int i = NW - TW; i < NW; i++) q.push_back(mk(K_W, i, 32'h0, 1'b0));
    end
  endfunction

  initial begin : model
    step_t hd;
    bit has_hd, cpu_eff, eng_req, cont, g_cpu, g_eng, e_we, e_re;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, sd;
    int pm;
    forever begin
      @(negedge clk);
      if (preload_go) for (int i = 0; i < 2048; i++) shadow[i] = pre_val(i, preload_kind);
      if (!rst_n) begin
        m_mode = 0; q.delete(); m_ack = 1'b0; m_ptr_cpu = 1'b1;
        m_rdata = '0; m_hold = '0; m_last_addr = '0; m_last_wdata = '0;
      end
      has_hd = (m_mode == 1) && (q.size() > 0);
      if (has_hd) hd = q[0];
      else hd = mk(K_WAIT, 0, 32'h0, 1'b0);
      eng_req = has_hd && (hd.kind != K_WAIT);
      cpu_eff = bus.cpu_req && !m_ack;
      cont = cpu_eff && eng_req;
      g_cpu = cont ? (PRIO || m_ptr_cpu) : cpu_eff;
      g_eng = eng_req && !g_cpu;
      sd = hd.use_hold ? m_hold : hd.data;
      e_we = g_cpu ? bus.cpu_we : (g_eng && hd.kind == K_W);
      e_re = g_cpu ? !bus.cpu_we : (g_eng && hd.kind == K_R);
      e_addr = g_cpu ? bus.cpu_addr : (g_eng ? hd.addr : m_last_addr);
      e_wdata = !e_we ? m_last_wdata : (g_cpu ? bus.cpu_wdata : sd);
      chk("ram_port", {bus.tram_we, bus.tram_re, bus.tram_addr, bus.tram_wdata}, {e_we, e_re, e_addr, e_wdata});
      chk("cpu_side", {bus.cpu_ack, bus.cpu_rdata}, {m_ack, m_rdata});
      chk("eng_status", {bus.busy, bus.done, bus.cmd_ready}, {m_mode != 0, m_mode == 2, m_mode == 0});
      if (rst_n) begin
        pm = m_mode;
        if (cont) m_ptr_cpu = !g_cpu;
        if (g_cpu || g_eng) m_last_addr = e_addr;
        if (e_we) m_last_wdata = e_wdata;
        if (g_cpu) begin
          if (bus.cpu_we) shadow[bus.cpu_addr] = bus.cpu_wdata;
          else m_rdata = shadow[bus.cpu_addr];
        end
        m_ack = g_cpu;
        if (g_eng) begin
          if (hd.kind == K_W) shadow[hd.addr] = sd;
          else m_hold = shadow[hd.addr];
          void'(q.pop_front());
        end else if (has_hd && hd.kind == K_WAIT) begin
          void'(q.pop_front());
        end
        if (pm == 1 && q.size() == 0) m_mode = 2;
        else if (pm == 2) m_mode = 0;
        else if (pm == 0 && bus.cmd_valid) begin
          build(bus.cmd_op, bus.cmd_row);
          m_mode = (q.size() > 0) ? 1 : 2;
        end
      end
    end
  end

  // All driver tasks start and end at posedge+1
  task automatic cpu_access(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            output logic [DW-1:0] rd, output int lat);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.cpu_ack && lat < 64);
    chk("cpu_ack_wait", bus.cpu_ack, 1'b1);
    rd = bus.cpu_rdata;
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
  endtask

  task automatic issue_cmd(input logic [1:0] op, input logic [7:0] row);
    int n;
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_row = row;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cmd_ready && n < 64);
    chk("cmd_ready_wait", bus.cmd_ready, 1'b1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n_we, output int n_cyc);
    n_we = 0; n_cyc = 0;
    do begin
      @(negedge clk);
      n_cyc++;
      if (bus.tram_we) n_we++;
    end while (!bus.done && n_cyc < budget);
    chk("done_seen", bus.done, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic preload(input bit kind);
    preload_kind = kind; preload_go = 1'b1;
    @(posedge clk); #1;
    preload_go = 1'b0;
  endtask

  task automatic cpu_traffic(input bit reads_only);
    logic [DW-1:0] rd;
    int lat, gap;
    while (!cpu_stop) begin
      gap = reads_only ? 0 : $urandom_range(0, 3);
      if (gap != 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      if (reads_only) cpu_access(1'b0, AW'($urandom_range(0, 2047)), 32'h0, rd, lat);
      else cpu_access(1'($urandom_range(0, 1)), AW'($urandom_range(0, 2047)), $urandom, rd, lat);
    end
  endtask

  task automatic cmd_with_traffic(input logic [1:0] op, input logic [7:0] row, input bit reads_only,
                                  output int n_we, output int n_cyc);
    int w, c;
    cpu_stop = 1'b0;
    fork
      begin
        issue_cmd(op, row);
        wait_done(12000, w, c);
        cpu_stop = 1'b1;
      end
      cpu_traffic(reads_only);
    join
    n_we = w; n_cyc = c;
  endtask

  initial begin : main
    logic [DW-1:0] rd;
    int lat, n_we, n_cyc, bad;
    logic [1:0] op;
    logic [7:0] row;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_row = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    preload(1'b0);
    @(negedge clk);
    chk("rst_status", {bus.busy, bus.done, bus.cmd_ready, bus.cpu_ack}, 4'b0010);
    chk("rst_port", {bus.tram_we, bus.tram_re, bus.tram_addr, bus.tram_wdata, bus.cpu_rdata}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // CPU write then read back
    cpu_access(1'b1, 11'd5, 32'h00AA55, rd, lat);
    chk("cpu_wr_lat", lat, 2);
    cpu_access(1'b0, 11'd5, 32'h0, rd, lat);
    chk("cpu_rd_lat", lat, 2);
    chk("cpu_rd_data", rd, 32'h00AA55);

    // CLEAR_ALL over a patterned map
    preload(1'b1);
    issue_cmd(2'd0, 8'd0);
    wait_done(3000, n_we, n_cyc);
    chk("clrall_writes", n_we, 2016);
    chk("clrall_done_cyc", n_cyc, 2017);
    chk("clrall_mem", {ram[0], ram[1000], ram[2015]}, '0);

    // SCROLL_UP uncontended
    preload(1'b1);
    issue_cmd(2'd2, 8'd0);
    wait_done(7000, n_we, n_cyc);
    chk("scroll_writes", n_we, 2016);
    chk("scroll_done_cyc", n_cyc, 5881);
    chk("scroll_row0", {ram[0], ram[83]}, {32'd2, 32'd2});
    chk("scroll_row22", {ram[22 * TW], ram[22 * TW + 83]}, {32'd24, 32'd24});
    chk("scroll_row23", {ram[23 * TW], ram[2015]}, '0);

    // Out-of-range row and reserved op finish with no RAM access
    issue_cmd(2'd1, 8'd24);
    wait_done(10, n_we, n_cyc);
    chk("row24_done_cyc", n_cyc, 1);
    chk("row24_writes", n_we, 0);
    issue_cmd(2'd3, 8'd0);
    wait_done(10, n_we, n_cyc);
    chk("op3_done_cyc", n_cyc, 1);
    chk("op3_writes", n_we, 0);

    // Reset in the middle of a scroll, then a normal CLEAR_ROW
    preload(1'b1);
    issue_cmd(2'd2, 8'd0);
    repeat (100) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_status", {bus.busy, bus.cmd_ready, bus.tram_we, bus.tram_re}, 4'b0100);
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_we = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.tram_we || bus.tram_re) n_we++;
    end
    chk("midrst_quiet", n_we, 0);
    @(posedge clk); #1;
    issue_cmd(2'd1, 8'd5);
    wait_done(200, n_we, n_cyc);
    chk("row5_done_cyc", n_cyc, 85);
    chk("row5_writes", n_we, 84);
    chk("row5_mem", {ram[5 * TW], ram[6 * TW - 1], ram[6 * TW]}, {32'd0, 32'd0, 32'd7});

    // CLEAR_ROW 3 against back-to-back CPU reads
    preload(1'b1);
    cmd_with_traffic(2'd1, 8'd3, 1'b1, n_we, n_cyc);
    chk("row3_writes", n_we, 84);
    bad = 0;
    for (int a = 252; a <= 335; a++) if (ram[a] !== 32'h0) bad++;
    chk("row3_cleared", bad, 0);
    chk("row3_edges", {ram[251], ram[336]}, {32'd3, 32'd5});

    // Randomized commands under random CPU traffic
    for (int it = 0; it < 8; it++) begin
      if (it == 2) op = 2'd2;
      else if (it == 5) op = 2'd0;
      else op = 2'($urandom_range(1, 3));
      row = 8'($urandom_range(0, 27));
      cmd_with_traffic(op, row, 1'b0, n_we, n_cyc);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog at %0t: got timeout expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
